// File: rtl/apu_dmc_reader.sv
// apu_dmc_reader: DMC sample memory reader for the 2A03 APU.
// Decodes $4010/$4012/$4013/$4015 writes, fetches sample bytes over the APU master
// port and holds one byte for the DMC output unit. It raises the DMC IRQ when a
// non-looping sample ends.
// Ports:
//   i_clk, i_rstn                      clock, asynchronous active-low reset
//   i_reg_addr/i_reg_wn/i_reg_wdata    CPU register bus (i_reg_wn=0 is a write strobe)
//   o_reg_rdata                        $4015 read contribution {irq, 2'b0, active, 4'b0}, combinational
//   o_dmc_req/i_dmc_gnt/o_dmc_addr     fetch request, one-cycle grant, fetch address
//   i_dmc_smpl                         fetched byte, valid with i_dmc_gnt
//   i_buf_pop/o_buf_full/o_buf_data    one-byte sample buffer towards the output unit
//   o_irq_n                            DMC IRQ, active-low
module apu_dmc_reader (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic [15:0] i_reg_addr,
    input  logic        i_reg_wn,
    input  logic [7:0]  i_reg_wdata,
    output logic [7:0]  o_reg_rdata,
    output logic        o_dmc_req,
    input  logic        i_dmc_gnt,
    output logic [15:0] o_dmc_addr,
    input  logic [7:0]  i_dmc_smpl,
    input  logic        i_buf_pop,
    output logic        o_buf_full,
    output logic [7:0]  o_buf_data,
    output logic        o_irq_n
);

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned LEN_W  = 12;
    localparam int unsigned DATA_W = 8;

    localparam logic [ADDR_W-1:0] REG_CTRL   = 16'h4010;
    localparam logic [ADDR_W-1:0] REG_ADDR   = 16'h4012;
    localparam logic [ADDR_W-1:0] REG_LEN    = 16'h4013;
    localparam logic [ADDR_W-1:0] REG_STATUS = 16'h4015;
    localparam logic [ADDR_W-1:0] SAMP_BASE  = 16'hC000;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    state_t              state;
    logic                irq_en;
    logic                loop_en;
    logic                dmc_irq;
    logic [DATA_W-1:0]   samp_addr;
    logic [DATA_W-1:0]   samp_len;
    logic [LEN_W-1:0]    bytes_rem;
    logic [ADDR_W-1:0]   cur_addr;
    logic                buf_full;
    logic [DATA_W-1:0]   buf_data;

    logic [ADDR_W-1:0]   start_addr;
    logic [LEN_W-1:0]    samp_length;
    logic [ADDR_W-1:0]   next_addr;
    logic                active;
    logic                reg_wr;

    // Sample geometry derived from the programmed registers
    assign start_addr  = SAMP_BASE + {2'b00, samp_addr, 6'b000000};
    assign samp_length = {samp_len, 4'b0000} + LEN_W'(1);
    // Fetch address stays in cartridge space: $FFFF rolls over to $8000
    assign next_addr   = (cur_addr == 16'hFFFF) ? 16'h8000 : cur_addr + ADDR_W'(1);
    assign active      = (bytes_rem != '0);
    assign reg_wr      = ~i_reg_wn;

    // Fetch sequencer, sample buffer and register file
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state     <= S_IDLE;
            irq_en    <= 1'b0;
            loop_en   <= 1'b0;
            dmc_irq   <= 1'b0;
            samp_addr <= '0;
            samp_len  <= '0;
            bytes_rem <= '0;
            cur_addr  <= SAMP_BASE;
            buf_full  <= 1'b0;
            buf_data  <= '0;
        end else begin
            if (i_buf_pop && buf_full) begin
                buf_full <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (!buf_full && active) begin
                        state <= S_REQ;
                    end
                end
                S_REQ: begin
                    // Request is held until granted, even if the sample was stopped meanwhile
                    if (i_dmc_gnt) begin
                        state    <= S_IDLE;
                        buf_full <= 1'b1;
                        buf_data <= i_dmc_smpl;
                        cur_addr <= next_addr;
                        if (bytes_rem == LEN_W'(1)) begin
                            if (loop_en) begin
                                cur_addr  <= start_addr;
                                bytes_rem <= samp_length;
                            end else begin
                                bytes_rem <= '0;
                                dmc_irq   <= irq_en;
                            end
                        end else if (bytes_rem != '0) begin
                            bytes_rem <= bytes_rem - LEN_W'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase

            // Placed last so a simultaneous CPU write overrides the fetch bookkeeping
            if (reg_wr) begin
                case (i_reg_addr)
                    REG_CTRL: begin
                        irq_en  <= i_reg_wdata[7];
                        loop_en <= i_reg_wdata[6];
                        if (!i_reg_wdata[7]) begin
                            dmc_irq <= 1'b0;
                        end
                    end
                    REG_ADDR: samp_addr <= i_reg_wdata;
                    REG_LEN:  samp_len  <= i_reg_wdata;
                    REG_STATUS: begin
                        dmc_irq <= 1'b0;
                        if (!i_reg_wdata[4]) begin
                            bytes_rem <= '0;
                        end else if (!active) begin
                            cur_addr  <= start_addr;
                            bytes_rem <= samp_length;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // $4015 read contribution
    always_comb begin
        o_reg_rdata = '0;
        if (i_reg_wn && (i_reg_addr == REG_STATUS)) begin
            o_reg_rdata = {dmc_irq, 2'b00, active, 4'b0000};
        end
    end

    assign o_dmc_req  = (state == S_REQ);
    assign o_dmc_addr = cur_addr;
    assign o_buf_full = buf_full;
    assign o_buf_data = buf_data;
    assign o_irq_n    = ~dmc_irq;

endmodule

// File: tb/tb_apu_dmc_reader.sv
// tb_apu_dmc_reader: randomized bench for apu_dmc_reader against a sample-level
// reference model (register file, byte counter, address sequence, IRQ flag).
module tb_apu_dmc_reader;

    logic        clk;
    logic        rstn;
    logic [15:0] reg_addr;
    logic        reg_wn;
    logic [7:0]  reg_wdata;
    logic [7:0]  reg_rdata;
    logic        dmc_req;
    logic        dmc_gnt;
    logic [15:0] dmc_addr;
    logic [7:0]  dmc_smpl;
    logic        buf_pop;
    logic        buf_full;
    logic [7:0]  buf_data;
    logic        irq_n;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit       m_irq_en, m_loop, m_irq, m_full;
    int       m_saddr, m_slen, m_rem, m_addr;
    bit [7:0] m_data;

    apu_dmc_reader dut (
        .i_clk       (clk),
        .i_rstn      (rstn),
        .i_reg_addr  (reg_addr),
        .i_reg_wn    (reg_wn),
        .i_reg_wdata (reg_wdata),
        .o_reg_rdata (reg_rdata),
        .o_dmc_req   (dmc_req),
        .i_dmc_gnt   (dmc_gnt),
        .o_dmc_addr  (dmc_addr),
        .i_dmc_smpl  (dmc_smpl),
        .i_buf_pop   (buf_pop),
        .o_buf_full  (buf_full),
        .o_buf_data  (buf_data),
        .o_irq_n     (irq_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int start_addr();
        return 32'hC000 + m_saddr * 64;
    endfunction

    function automatic int samp_length();
        return m_slen * 16 + 1;
    endfunction

    function automatic logic [7:0] exp_rdata();
        return {m_irq, 2'b00, (m_rem != 0), 4'b0000};
    endfunction

    task automatic model_reset();
        m_irq_en = 0; m_loop = 0; m_irq = 0; m_full = 0;
        m_saddr = 0; m_slen = 0; m_rem = 0; m_addr = 32'hC000; m_data = 8'h00;
    endtask

    task automatic model_grant(input bit [7:0] smpl);
        m_full = 1;
        m_data = smpl;
        m_addr = (m_addr == 32'hFFFF) ? 32'h8000 : m_addr + 1;
        if (m_rem == 1) begin
            if (m_loop) begin
                m_addr = start_addr();
                m_rem  = samp_length();
            end else begin
                m_rem = 0;
                if (m_irq_en) m_irq = 1;
            end
        end else if (m_rem > 1) begin
            m_rem = m_rem - 1;
        end
    endtask

    task automatic chk_status(input string tag);
        chk_eq({tag, "_irq_n"}, 32'(irq_n), 32'(!m_irq));
        chk_eq({tag, "_rdata"}, 32'(reg_rdata), 32'(exp_rdata()));
        chk_eq({tag, "_full"}, 32'(buf_full), 32'(m_full));
    endtask

    task automatic reg_write(input logic [15:0] a, input logic [7:0] d);
        reg_addr  = a;
        reg_wdata = d;
        reg_wn    = 1'b0;
        tick();
        reg_wn    = 1'b1;
        reg_addr  = 16'h4015;
        case (a)
            16'h4010: begin
                m_irq_en = d[7];
                m_loop   = d[6];
                if (!d[7]) m_irq = 0;
            end
            16'h4012: m_saddr = int'(d);
            16'h4013: m_slen  = int'(d);
            16'h4015: begin
                m_irq = 0;
                if (!d[4]) m_rem = 0;
                else if (m_rem == 0) begin
                    m_addr = start_addr();
                    m_rem  = samp_length();
                end
            end
            default: ;
        endcase
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk_eq("idle_req", 32'(dmc_req), 32'd0);
            chk_status("idle");
        end
    endtask

    // Expects req low now (just after a write/pop edge) and high one edge later
    task automatic wait_req_rise(output bit ok);
        int n;
        chk_eq("req_pre", 32'(dmc_req), 32'd0);
        tick();
        chk_eq("req_rise", 32'(dmc_req), 32'd1);
        n = 0;
        while (!dmc_req && n < 10) begin
            tick();
            n++;
        end
        if (!dmc_req) chk_eq("req_timeout", 32'(dmc_req), 32'd1);
        ok = dmc_req;
    endtask

    task automatic grant_byte(input int gdelay, input bit [7:0] smpl);
        chk_eq("req_addr", 32'(dmc_addr), 32'(m_addr));
        for (int i = 0; i < gdelay; i++) begin
            tick();
            chk_eq("req_hold", 32'(dmc_req), 32'd1);
            chk_eq("req_addr_stable", 32'(dmc_addr), 32'(m_addr));
        end
        dmc_gnt  = 1'b1;
        dmc_smpl = smpl;
        tick();
        dmc_gnt  = 1'b0;
        dmc_smpl = 8'h00;
        model_grant(smpl);
        chk_eq("gnt_req_drop", 32'(dmc_req), 32'd0);
        chk_eq("gnt_data", 32'(buf_data), 32'(m_data));
        chk_eq("gnt_next_addr", 32'(dmc_addr), 32'(m_addr));
        chk_status("gnt");
    endtask

    task automatic pop_byte(input int delay);
        for (int i = 0; i < delay; i++) begin
            tick();
            chk_eq("full_no_req", 32'(dmc_req), 32'd0);
        end
        buf_pop = 1'b1;
        tick();
        buf_pop = 1'b0;
        m_full  = 0;
        chk_eq("pop_full", 32'(buf_full), 32'd0);
    endtask

    initial begin
        bit ok;
        rstn      = 1'b0;
        reg_addr  = 16'h4015;
        reg_wn    = 1'b1;
        reg_wdata = 8'h00;
        dmc_gnt   = 1'b0;
        dmc_smpl  = 8'h00;
        buf_pop   = 1'b0;
        model_reset();

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk_eq("rst_req", 32'(dmc_req), 32'd0);
        chk_eq("rst_addr", 32'(dmc_addr), 32'hC000);
        chk_eq("rst_data", 32'(buf_data), 32'd0);
        chk_status("rst");
        rstn = 1'b1;
        idle(100);

        // Pop while empty is ignored
        buf_pop = 1'b1;
        tick();
        buf_pop = 1'b0;
        chk_eq("pop_empty", 32'(buf_full), 32'd0);

        // Single fetch
        reg_write(16'h4012, 8'h10);
        reg_write(16'h4013, 8'h00);
        reg_write(16'h4015, 8'h10);
        wait_req_rise(ok);
        chk_eq("single_addr", 32'(dmc_addr), 32'hC400);
        grant_byte(2, 8'h5A);
        chk_eq("single_data", 32'(buf_data), 32'h5A);
        chk_eq("single_active", 32'(reg_rdata[4]), 32'd0);
        idle(10);
        pop_byte(1);
        idle(5);

        // IRQ after 17 bytes
        reg_write(16'h4010, 8'h80);
        reg_write(16'h4012, 8'h00);
        reg_write(16'h4013, 8'h01);
        reg_write(16'h4015, 8'h10);
        for (int i = 0; i < 17; i++) begin
            wait_req_rise(ok);
            if (!ok) break;
            chk_eq("irq_seq_addr", 32'(dmc_addr), 32'hC000 + 32'(i));
            grant_byte(int'($urandom_range(0, 2)), 8'($urandom));
            if (i < 16) begin
                chk_eq("irq_early", 32'(irq_n), 32'd1);
                pop_byte(int'($urandom_range(0, 2)));
            end
        end
        chk_eq("irq_set", 32'(irq_n), 32'd0);
        pop_byte(0);
        idle(5);
        reg_write(16'h4015, 8'h00);
        chk_eq("irq_clear", 32'(irq_n), 32'd1);

        // Looping one-byte sample at $FFC0
        reg_write(16'h4010, 8'h40);
        reg_write(16'h4013, 8'h00);
        reg_write(16'h4012, 8'hFF);
        reg_write(16'h4015, 8'h10);
        for (int i = 0; i < 5; i++) begin
            wait_req_rise(ok);
            if (!ok) break;
            chk_eq("loop_addr", 32'(dmc_addr), 32'hFFC0);
            grant_byte(int'($urandom_range(0, 3)), 8'($urandom));
            chk_eq("loop_no_irq", 32'(irq_n), 32'd1);
            if (i < 4) pop_byte(int'($urandom_range(0, 2)));
        end
        reg_write(16'h4015, 8'h00);
        pop_byte(1);
        idle(5);

        // Address wrap $FFFF -> $8000
        reg_write(16'h4010, 8'h00);
        reg_write(16'h4012, 8'hFF);
        reg_write(16'h4013, 8'h04);
        reg_write(16'h4015, 8'h10);
        for (int i = 0; i < 65; i++) begin
            wait_req_rise(ok);
            if (!ok) break;
            if (i == 63) chk_eq("wrap_64th", 32'(dmc_addr), 32'hFFFF);
            if (i == 64) chk_eq("wrap_65th", 32'(dmc_addr), 32'h8000);
            grant_byte(int'($urandom_range(0, 1)), 8'($urandom));
            pop_byte(0);
        end
        idle(5);

        // Disable while a request is pending
        reg_write(16'h4013, 8'h01);
        reg_write(16'h4015, 8'h10);
        wait_req_rise(ok);
        reg_write(16'h4015, 8'h00);
        chk_eq("dis_req_held", 32'(dmc_req), 32'd1);
        chk_eq("dis_inactive", 32'(reg_rdata), 32'h00);
        grant_byte(1, 8'hA5);
        chk_eq("dis_data", 32'(buf_data), 32'hA5);
        pop_byte(0);
        idle(10);

        // Randomized samples
        for (int e = 0; e < 12; e++) begin
            bit       lp, ie;
            bit [7:0] sa;
            int       nb;
            lp = 1'($urandom_range(0, 1));
            ie = 1'($urandom_range(0, 1));
            sa = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            reg_write(16'h4010, {ie, lp, 6'($urandom)});
            reg_write(16'h4012, sa);
            reg_write(16'h4013, 8'($urandom_range(0, 2)));
            reg_write(16'h4015, 8'($urandom) | 8'h10);
            nb = lp ? m_rem + int'($urandom_range(1, 4)) : m_rem;
            for (int i = 0; i < nb; i++) begin
                wait_req_rise(ok);
                if (!ok) break;
                grant_byte(int'($urandom_range(0, 3)), 8'($urandom));
                if (i != nb - 1) begin
                    if ($urandom_range(0, 3) == 0 && m_rem != 0) reg_write(16'h4015, 8'h10);
                    pop_byte(int'($urandom_range(0, 2)));
                end
            end
            if (lp) reg_write(16'h4015, 8'h00);
            pop_byte(int'($urandom_range(0, 2)));
            idle(3);
        end

        // Asynchronous reset while a request is pending
        reg_write(16'h4010, 8'h80);
        reg_write(16'h4012, 8'h22);
        reg_write(16'h4013, 8'h01);
        reg_write(16'h4015, 8'h10);
        wait_req_rise(ok);
        #2;
        rstn = 1'b0;
        #1;
        chk_eq("arst_req", 32'(dmc_req), 32'd0);
        chk_eq("arst_addr", 32'(dmc_addr), 32'hC000);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        model_reset();
        chk_status("arst");
        idle(5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
